// File: rtl/nts_dispatch_reader_pkg.sv
// Shared types and helpers for the NTS dispatcher read-out path:
// FSM encoding, stream field widths and last-word mask decoding.
package nts_dispatch_reader_pkg;

    localparam int DATA_W   = 64;
    localparam int LBYTES_W = 4;
    localparam int LEN_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_READ,
        ST_DRAIN,
        ST_DISCARD,
        ST_WAIT_CLEAR
    } state_t;

    function automatic logic [LBYTES_W-1:0] popcount8(input logic [7:0] m);
        logic [LBYTES_W-1:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + LBYTES_W'(m[i]);
        end
        return c;
    endfunction

    // A legal mask is a contiguous run of ones starting at byte 0, so mask+1 is a power of two.
    function automatic logic mask_ok(input logic [7:0] m);
        logic [8:0] p;
        p = {1'b0, m} + 9'd1;
        return (m != 8'd0) && ((p & (p - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/nts_skid_fifo2.sv
// Two-entry valid/ready buffer; the head register drives the output so data
// holds steady while the consumer stalls.
module nts_skid_fifo2 #(
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             pop;

    assign pop         = (count_q != 2'd0) && out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign occupancy_o = count_q;

    // The writer never pushes into a full buffer without a simultaneous pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({in_valid_i, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= in_data_i;
                    else                 tail_q <= in_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= in_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nts_dispatch_reader.sv
// Reads completed packets out of the NTS dispatcher buffer and streams them to the parser.
// Optional statistics outputs are enabled by defining NTS_DISPATCH_READER_STATS_EN.
module nts_dispatch_reader
    import nts_dispatch_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MIN_BYTES  = 48,
    parameter int MAX_BYTES  = 1536
) (
    input  logic                  i_areset,
    input  logic                  i_clk,
    input  logic                  i_dispatch_packet_available,
    output logic                  o_dispatch_packet_read_discard,
    input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
    input  logic [7:0]            i_dispatch_data_valid,
    input  logic                  i_dispatch_fifo_empty,
    output logic                  o_dispatch_fifo_rd_en,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_pkt_valid,
    input  logic                  i_pkt_ready,
    output logic [63:0]           o_pkt_data,
    output logic                  o_pkt_first,
    output logic                  o_pkt_last,
    output logic [3:0]            o_pkt_last_bytes,
    output logic [15:0]           o_pkt_length,
    output logic                  o_pkt_drop
`ifdef NTS_DISPATCH_READER_STATS_EN
    ,
    output logic [31:0]           o_stat_packets,
    output logic [31:0]           o_stat_dropped,
    output logic [31:0]           o_stat_words
`endif
);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] counter_q;
    logic [7:0]            mask_q;
    logic [LBYTES_W-1:0]   lbytes_q;
    logic [LEN_W-1:0]      length_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic                  inflight_q;
    logic                  first_pend_q;
    logic                  last_pend_q;
    logic                  underrun_q;
    logic                  discard_q;
    logic                  drop_q;

    logic [DATA_W+1:0]     skid_out;
    logic                  skid_valid;
    logic [1:0]            skid_occ;
    logic                  pop;
    logic [2:0]            committed;
    logic                  last_issue;
    logic                  rd_en;
    logic [LEN_W-1:0]      len_calc;
    logic                  pkt_ok;
    logic                  forced_last;
    logic                  word_last;

    assign pop        = skid_valid & i_pkt_ready;
    // Count the word leaving this cycle as free space so back-to-back reads reach 1 word/cycle.
    assign committed  = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign last_issue = (issued_q == {1'b0, counter_q});
    assign rd_en      = (state_q == ST_READ) && !i_dispatch_fifo_empty &&
                        (issued_q <= {1'b0, counter_q}) && (committed < 3'd2);

    assign len_calc = (LEN_W'(counter_q) << 3) + LEN_W'(popcount8(mask_q));
    assign pkt_ok   = mask_ok(mask_q) && (len_calc >= LEN_W'(MIN_BYTES)) &&
                      (len_calc <= LEN_W'(MAX_BYTES));

    // After an underrun the only remaining buffered word closes the packet.
    assign forced_last = underrun_q && (skid_occ == 2'd1) && !inflight_q;
    assign word_last   = skid_valid && (skid_out[0] || forced_last);

    assign o_dispatch_fifo_rd_en          = rd_en;
    assign o_dispatch_packet_read_discard = discard_q;
    assign o_pkt_drop                     = drop_q;
    assign o_pkt_valid                    = skid_valid;
    assign o_pkt_data                     = skid_out[DATA_W+1:2];
    assign o_pkt_first                    = skid_valid & skid_out[1];
    assign o_pkt_last                     = word_last;
    assign o_pkt_last_bytes               = word_last ? (skid_out[0] ? lbytes_q : 4'd8) : 4'd0;
    assign o_pkt_length                   = length_q;

    nts_skid_fifo2 #(.WIDTH(DATA_W + 2)) u_skid (
        .clk_i       (i_clk),
        .rst_i       (i_areset),
        .in_valid_i  (inflight_q),
        .in_data_i   ({i_dispatch_fifo_rd_data, first_pend_q, last_pend_q}),
        .out_valid_o (skid_valid),
        .out_ready_i (i_pkt_ready),
        .out_data_o  (skid_out),
        .occupancy_o (skid_occ)
    );

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            mask_q       <= '0;
            lbytes_q     <= '0;
            length_q     <= '0;
            issued_q     <= '0;
            inflight_q   <= 1'b0;
            first_pend_q <= 1'b0;
            last_pend_q  <= 1'b0;
            underrun_q   <= 1'b0;
            discard_q    <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            inflight_q   <= rd_en;
            first_pend_q <= (issued_q == '0);
            last_pend_q  <= last_issue;
            discard_q    <= 1'b0;
            drop_q       <= 1'b0;
            if (rd_en) issued_q <= issued_q + (ADDR_WIDTH + 1)'(1);
            case (state_q)
                ST_IDLE: begin
                    if (i_dispatch_packet_available) begin
                        counter_q <= i_dispatch_counter;
                        mask_q    <= i_dispatch_data_valid;
                        state_q   <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    lbytes_q   <= popcount8(mask_q);
                    length_q   <= len_calc;
                    issued_q   <= '0;
                    underrun_q <= 1'b0;
                    if (pkt_ok) begin
                        state_q <= ST_READ;
                    end else begin
                        state_q   <= ST_DISCARD;
                        discard_q <= 1'b1;
                        drop_q    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_en && last_issue) begin
                        state_q <= ST_DRAIN;
                    end else if (i_dispatch_fifo_empty) begin
                        underrun_q <= 1'b1;
                        state_q    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((pop && word_last) || (underrun_q && skid_occ == 2'd0 && !inflight_q)) begin
                        state_q   <= ST_DISCARD;
                        discard_q <= 1'b1;
                        drop_q    <= underrun_q;
                    end
                end
                ST_DISCARD:    state_q <= ST_WAIT_CLEAR;
                ST_WAIT_CLEAR: if (!i_dispatch_packet_available) state_q <= ST_IDLE;
                default:       state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef NTS_DISPATCH_READER_STATS_EN
    logic [31:0] stat_packets_q;
    logic [31:0] stat_dropped_q;
    logic [31:0] stat_words_q;

    assign o_stat_packets = stat_packets_q;
    assign o_stat_dropped = stat_dropped_q;
    assign o_stat_words   = stat_words_q;

    // Saturating counters: truncated packets count as drops, not forwards.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_packets_q <= '0;
            stat_dropped_q <= '0;
            stat_words_q   <= '0;
        end else begin
            if (pop && word_last && !underrun_q && stat_packets_q != '1)
                stat_packets_q <= stat_packets_q + 32'd1;
            if (drop_q && stat_dropped_q != '1)
                stat_dropped_q <= stat_dropped_q + 32'd1;
            if (pop && stat_words_q != '1)
                stat_words_q <= stat_words_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nts_dispatch_reader.sv
// Self-checking bench for nts_dispatch_reader: a dispatcher responder model feeds words,
// a monitor records the output stream, and each test compares against a packet-level model.
module tb_nts_dispatch_reader;

    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
        logic [3:0]  lb;
        logic [15:0] len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avail = 1'b0;
    logic [7:0]  cnt_in = 8'd0;
    logic [7:0]  dv_in = 8'd0;
    logic        empty;
    logic [63:0] rd_data = 64'd0;
    logic        ready = 1'b0;

    logic        o_discard, o_rd_en, o_valid, o_first, o_last, o_drop;
    logic [63:0] o_data;
    logic [3:0]  o_lbytes;
    logic [15:0] o_length;
    logic [89:0] all_out;

    always #5 clk = ~clk;

    nts_dispatch_reader dut (
        .i_areset                       (rst),
        .i_clk                          (clk),
        .i_dispatch_packet_available    (avail),
        .o_dispatch_packet_read_discard (o_discard),
        .i_dispatch_counter             (cnt_in),
        .i_dispatch_data_valid          (dv_in),
        .i_dispatch_fifo_empty          (empty),
        .o_dispatch_fifo_rd_en          (o_rd_en),
        .i_dispatch_fifo_rd_data        (rd_data),
        .o_pkt_valid                    (o_valid),
        .i_pkt_ready                    (ready),
        .o_pkt_data                     (o_data),
        .o_pkt_first                    (o_first),
        .o_pkt_last                     (o_last),
        .o_pkt_last_bytes               (o_lbytes),
        .o_pkt_length                   (o_length),
        .o_pkt_drop                     (o_drop)
    );

    assign all_out = {o_valid, o_data, o_first, o_last, o_lbytes, o_length, o_drop, o_discard, o_rd_en};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Dispatcher responder: word data appears the cycle after each read enable.
    logic [63:0] words [0:63];
    int rd_total = 0;
    int rd_start = 0;
    int rd_limit = 0;
    always @(posedge clk) begin
        if (o_rd_en) begin
            rd_data  <= words[rd_total - rd_start];
            rd_total <= rd_total + 1;
        end
    end
    assign empty = (rd_total - rd_start) >= rd_limit;

    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: accepted beats, pulses and stall-stability violations.
    beat_t acc_q[$];
    int    acc_cyc[$];
    int    valid_seen = 0, discard_cnt = 0, drop_cnt = 0;
    int    discard_cyc = 0, drop_cyc = 0, stall_viol = 0;
    beat_t snap;
    bit    stall_pend = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        cur = {o_data, o_first, o_last, o_lbytes, o_length};
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend && (!o_valid || cur !== snap)) stall_viol++;
            stall_pend = o_valid && !ready;
            snap = cur;
            if (o_valid) valid_seen++;
            if (o_valid && ready) begin
                acc_q.push_back(cur);
                acc_cyc.push_back(cyc);
            end
            if (o_discard) begin discard_cnt++; discard_cyc = cyc; end
            if (o_drop)    begin drop_cnt++;    drop_cyc = cyc;    end
        end
    end

    int acc_base, disc_base, drop_base, valid_base, viol_base, start_cyc;

    // Packet-level reference: what the reader should forward and whether it drops.
    task automatic model(input int cnt, input int mask, input int limit,
                         output int n, output bit drop, output int len, output int lb);
        bit ok = 1'b0;
        lb = $countones(mask & 255);
        for (int k = 1; k <= 8; k++) if (mask == (1 << k) - 1) ok = 1'b1;
        len = cnt * 8 + lb;
        if (!ok || len < 48 || len > 1536) begin n = 0; drop = 1'b1; end
        else if (limit < cnt + 1)          begin n = limit; drop = 1'b1; end
        else                               begin n = cnt + 1; drop = 1'b0; end
    endtask

    function automatic beat_t exp_beat(input int i, input int n, input int len, input int lb);
        beat_t b;
        b.d   = words[i];
        b.f   = (i == 0);
        b.l   = (i == n - 1);
        b.lb  = (i == n - 1) ? 4'(lb) : 4'd0;
        b.len = 16'(len);
        return b;
    endfunction

    task automatic start_pkt(input int cnt, input int mask, input int limit, input int rmode);
        @(negedge clk);
        ready_mode = rmode;
        for (int i = 0; i < 64; i++) words[i] = {$urandom, $urandom};
        rd_start   = rd_total;
        rd_limit   = limit;
        acc_base   = acc_q.size();
        disc_base  = discard_cnt;
        drop_base  = drop_cnt;
        valid_base = valid_seen;
        viol_base  = stall_viol;
        start_cyc  = cyc;
        cnt_in     = 8'(cnt);
        dv_in      = 8'(mask);
        avail      = 1'b1;
    endtask

    task automatic run_pkt(input int cnt, input int mask, input int limit, input int rmode);
        int k;
        start_pkt(cnt, mask, limit, rmode);
        for (k = 0; k < 500 && discard_cnt == disc_base; k++) begin
            @(negedge clk);
            #1;
        end
        if (discard_cnt == disc_base) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout waiting for discard: got none, required one within 500 cycles");
        end
        @(negedge clk);
        avail = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_hold: got %h required 0", all_out); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_idle: got %h required 0", all_out); end
    endtask

    task automatic test_full_rate();
        int n, len, lb; bit drop;
        run_pkt(7, 'hff, 8, 0);
        model(7, 'hff, 8, n, drop, len, lb);
        checks++;
        if (acc_q.size() - acc_base !== n) begin errors++; $display("[TB] FAIL full_rate count: got %0d required %0d", acc_q.size() - acc_base, n); end
        for (int i = 0; i < n && acc_base + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[acc_base + i] !== exp_beat(i, n, len, lb)) begin
                errors++; $display("[TB] FAIL full_rate beat %0d: got %h required %h", i, acc_q[acc_base + i], exp_beat(i, n, len, lb));
            end
        end
        if (acc_q.size() - acc_base == n) begin
            checks++;
            if (acc_cyc[acc_base + n - 1] - acc_cyc[acc_base] !== n - 1) begin
                errors++; $display("[TB] FAIL full_rate span: got %0d required %0d", acc_cyc[acc_base + n - 1] - acc_cyc[acc_base], n - 1);
            end
        end
        checks++;
        if (discard_cnt - disc_base !== 1) begin errors++; $display("[TB] FAIL full_rate discards: got %0d required 1", discard_cnt - disc_base); end
        checks++;
        if (drop_cnt - drop_base !== 0) begin errors++; $display("[TB] FAIL full_rate drops: got %0d required 0", drop_cnt - drop_base); end
    endtask

    task automatic test_stall();
        int n, len, lb; bit drop;
        run_pkt(10, 'h0f, 11, 1);
        model(10, 'h0f, 11, n, drop, len, lb);
        checks++;
        if (acc_q.size() - acc_base !== n) begin errors++; $display("[TB] FAIL stall count: got %0d required %0d", acc_q.size() - acc_base, n); end
        for (int i = 0; i < n && acc_base + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[acc_base + i] !== exp_beat(i, n, len, lb)) begin
                errors++; $display("[TB] FAIL stall beat %0d: got %h required %h", i, acc_q[acc_base + i], exp_beat(i, n, len, lb));
            end
        end
        checks++;
        if (stall_viol - viol_base !== 0) begin errors++; $display("[TB] FAIL stall stability: got %0d violations required 0", stall_viol - viol_base); end
    endtask

    task automatic test_short();
        run_pkt(3, 'hff, 4, 0);
        checks++;
        if (valid_seen - valid_base !== 0) begin errors++; $display("[TB] FAIL short valid: got %0d valid cycles required 0", valid_seen - valid_base); end
        checks++;
        if (drop_cnt - drop_base !== 1) begin errors++; $display("[TB] FAIL short drops: got %0d required 1", drop_cnt - drop_base); end
        checks++;
        if (discard_cyc - start_cyc !== 2) begin errors++; $display("[TB] FAIL short latency: got %0d required 2", discard_cyc - start_cyc); end
        checks++;
        if (drop_cyc !== discard_cyc) begin errors++; $display("[TB] FAIL short align: drop at %0d required %0d", drop_cyc, discard_cyc); end
    endtask

    task automatic test_bad_mask();
        run_pkt(7, 'h05, 8, 0);
        checks++;
        if (valid_seen - valid_base !== 0) begin errors++; $display("[TB] FAIL bad_mask valid: got %0d required 0", valid_seen - valid_base); end
        checks++;
        if (drop_cnt - drop_base !== 1) begin errors++; $display("[TB] FAIL bad_mask drops: got %0d required 1", drop_cnt - drop_base); end
    endtask

    task automatic test_underrun();
        int n, len, lb; bit drop;
        beat_t a, e;
        run_pkt(20, 'hff, 5, 0);
        model(20, 'hff, 5, n, drop, len, lb);
        checks++;
        if (acc_q.size() - acc_base !== n) begin errors++; $display("[TB] FAIL underrun count: got %0d required %0d", acc_q.size() - acc_base, n); end
        for (int i = 0; i < n && acc_base + i < acc_q.size(); i++) begin
            a = acc_q[acc_base + i];
            e = exp_beat(i, n, len, lb);
            checks++;
            if ({a.d, a.f, a.l, a.len} !== {e.d, e.f, e.l, e.len}) begin
                errors++; $display("[TB] FAIL underrun beat %0d: got %h required %h", i, {a.d, a.f, a.l, a.len}, {e.d, e.f, e.l, e.len});
            end
        end
        checks++;
        if (drop_cnt - drop_base !== 32'(drop)) begin errors++; $display("[TB] FAIL underrun drops: got %0d required %0d", drop_cnt - drop_base, drop); end
        checks++;
        if (drop_cyc !== discard_cyc) begin errors++; $display("[TB] FAIL underrun align: drop at %0d required %0d", drop_cyc, discard_cyc); end
    endtask

    task automatic test_reset_mid();
        int n, len, lb, k; bit drop;
        start_pkt(15, 'hff, 16, 0);
        for (k = 0; k < 200 && acc_q.size() - acc_base < 4; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (acc_q.size() - acc_base < 4) begin errors++; $display("[TB] FAIL reset_mid progress: got %0d words required 4", acc_q.size() - acc_base); end
        disc_base = discard_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_mid outputs: got %h required 0", all_out); end
        avail = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (discard_cnt - disc_base !== 0) begin errors++; $display("[TB] FAIL reset_mid discard: got %0d required 0", discard_cnt - disc_base); end
        run_pkt(15, 'hff, 16, 2);
        model(15, 'hff, 16, n, drop, len, lb);
        checks++;
        if (acc_q.size() - acc_base !== n) begin errors++; $display("[TB] FAIL after_reset count: got %0d required %0d", acc_q.size() - acc_base, n); end
        for (int i = 0; i < n && acc_base + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[acc_base + i] !== exp_beat(i, n, len, lb)) begin
                errors++; $display("[TB] FAIL after_reset beat %0d: got %h required %h", i, acc_q[acc_base + i], exp_beat(i, n, len, lb));
            end
        end
    endtask

    task automatic test_random();
        int n, len, lb, cnt, mask; bit drop;
        for (int p = 0; p < 8; p++) begin
            cnt  = int'($urandom_range(2, 40));
            mask = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : (1 << $urandom_range(1, 8)) - 1;
            run_pkt(cnt, mask, cnt + 1, 2);
            model(cnt, mask, cnt + 1, n, drop, len, lb);
            checks++;
            if (acc_q.size() - acc_base !== n) begin errors++; $display("[TB] FAIL random %0d count: got %0d required %0d", p, acc_q.size() - acc_base, n); end
            for (int i = 0; i < n && acc_base + i < acc_q.size(); i++) begin
                checks++;
                if (acc_q[acc_base + i] !== exp_beat(i, n, len, lb)) begin
                    errors++; $display("[TB] FAIL random %0d beat %0d: got %h required %h", p, i, acc_q[acc_base + i], exp_beat(i, n, len, lb));
                end
            end
            checks++;
            if (drop_cnt - drop_base !== 32'(drop)) begin errors++; $display("[TB] FAIL random %0d drops: got %0d required %0d", p, drop_cnt - drop_base, drop); end
            checks++;
            if (stall_viol - viol_base !== 0) begin errors++; $display("[TB] FAIL random %0d stability: got %0d required 0", p, stall_viol - viol_base); end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_short();
        test_bad_mask();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
